// File: rtl/osc_bank.sv
// -----------------------------------------------------------------------------
// osc_bank
//
// Multi-channel clock-strobe generator. Each channel produces a 50%-duty square
// wave whose half-period (in system clock cycles) is programmable. Powering a
// channel down is glitch-free: the period in progress always completes, high
// phase then low phase, before the channel goes idle. A shared align input
// restarts every powered channel in phase.
//
// Parameters:
//   CHANNELS    number of independent oscillator channels (>= 1)
//   DIV_WIDTH   width of each half-period field (>= 1)
//
// Ports:
//   clock        in   system clock, all logic on its rising edge
//   reset        in   synchronous, active-high reset
//   power        in   [CHANNELS]            bit i enables channel i
//   half_period  in   [CHANNELS*DIV_WIDTH]  channel i at [i*DIV_WIDTH +: DIV_WIDTH];
//                                           0 behaves as 1
//   align        in   restart all powered channels in phase (one-cycle request)
//   osc          out  [CHANNELS]  registered square wave per channel
//   tick         out  [CHANNELS]  registered one-cycle pulse as osc rises
//   running      out  [CHANNELS]  registered, channel is not idle
// -----------------------------------------------------------------------------
module osc_bank #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           power,
    input  logic [CHANNELS*DIV_WIDTH-1:0] half_period,
    input  logic                          align,
    output logic [CHANNELS-1:0]           osc,
    output logic [CHANNELS-1:0]           tick,
    output logic [CHANNELS-1:0]           running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

        state_t               state, state_nx;
        logic [DIV_WIDTH-1:0] cnt, cnt_nx;
        logic [DIV_WIDTH-1:0] h, h_nx;
        logic [DIV_WIDTH-1:0] h_in;
        logic                 osc_q, osc_nx;
        logic                 tick_q, tick_nx;
        logic                 run_q, run_nx;
        logic                 at_end;
        logic                 start;

        // A programmed half-period of 0 is treated as 1 so the channel can
        // never stall with a counter target below zero.
        assign h_in = (half_period[i*DIV_WIDTH +: DIV_WIDTH] == '0)
                    ? ONE
                    : half_period[i*DIV_WIDTH +: DIV_WIDTH];

        // The counter runs 0..h-1 in each phase; h is always >= 1 so h-1
        // never wraps.
        assign at_end = (cnt == h - ONE);

        // Every path into HIGH shares the same entry action: from IDLE, at the
        // end of a LOW phase while still powered, or on an align request.
        // HIGH deliberately ignores power so a high phase always completes.
        assign start = power[i] &&
                       (align || (state == IDLE) || ((state == LOW) && at_end));

        always_comb begin
            // NOTE: every variable gets a default before any branch so no path
            // leaves it unassigned; otherwise synthesis would infer a latch.
            state_nx = state;
            cnt_nx   = cnt;
            h_nx     = h;
            osc_nx   = osc_q;
            tick_nx  = 1'b0;
            run_nx   = run_q;

            if (start) begin
                state_nx = HIGH;
                cnt_nx   = '0;
                h_nx     = h_in;
                osc_nx   = 1'b1;
                tick_nx  = 1'b1;
                run_nx   = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_nx = '0;
                        osc_nx = 1'b0;
                        run_nx = 1'b0;
                    end
                    HIGH: begin
                        if (at_end) begin
                            state_nx = LOW;
                            cnt_nx   = '0;
                            osc_nx   = 1'b0;
                        end else begin
                            cnt_nx = cnt + ONE;
                        end
                    end
                    LOW: begin
                        // The powered end-of-LOW case is covered by start.
                        if (at_end) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            run_nx   = 1'b0;
                        end else begin
                            cnt_nx = cnt + ONE;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        osc_nx   = 1'b0;
                        run_nx   = 1'b0;
                    end
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        always_ff @(posedge clock) begin
            if (reset) begin
                state  <= IDLE;
                cnt    <= '0;
                h      <= ONE;
                osc_q  <= 1'b0;
                tick_q <= 1'b0;
                run_q  <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                h      <= h_nx;
                osc_q  <= osc_nx;
                tick_q <= tick_nx;
                run_q  <= run_nx;
            end
        end

        assign osc[i]     = osc_q;
        assign tick[i]    = tick_q;
        assign running[i] = run_q;
    end

endmodule

// File: doc/osc_bank.md
# osc_bank

Multi-channel, synthesisable clock-strobe generator. Each of `CHANNELS` independent channels derives a 50%-duty square wave with programmable half-period from the single system clock. Per-channel power gating is glitch-free, with a global phase-align input. Sits beside the system clock source and drives slow strobes, such as peripheral bit clocks and timer ticks, to downstream logic in the same clock domain.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent oscillator channels (≥1).
- `DIV_WIDTH`, default 8: width of each half-period field (≥1).

Ports:
- `clock` in 1: system clock. All logic is on its rising edge. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `power` in `CHANNELS`: bit i enables channel i.
- `half_period` in `CHANNELS*DIV_WIDTH`: channel i uses bits `[i*DIV_WIDTH +: DIV_WIDTH]`, in clock cycles.
- `align` in 1: one-cycle request to restart all powered channels in phase.
- `osc` out `CHANNELS`: square-wave output per channel.
- `tick` out `CHANNELS`: one-cycle pulse, high in the same cycle `osc[i]` rises.
- `running` out `CHANNELS`: channel i is active, i.e. not IDLE.

## Operation
- Per-channel FSM with states IDLE, HIGH and LOW. Each channel also has a counter `cnt` (`DIV_WIDTH` bits) and a latched half-period `h`.
- Effective half-period is `h = max(half_period[i], 1)`, so 0 behaves as 1. It is latched only on entry to HIGH. Changes to `half_period` mid-period have no effect until the next period starts.
- Channel output period is 2·h cycles with exact 50% duty. `osc[i]`, `tick[i]` and `running[i]` are all registered outputs.
- IDLE: `osc`=0, `running`=0, `cnt`=0.
  - On an edge with `power[i]`=1, go to HIGH: `cnt`=0, latch `h`, `osc`=1, `tick`=1, `running`=1.
- HIGH:
  - If `cnt`==h-1: go to LOW, `cnt`=0, `osc`=0.
  - Otherwise `cnt`++.
  - `power` is not examined, so a high phase always completes.
- LOW:
  - If `cnt`==h-1 and `power[i]`=1: go to HIGH, relatch `h`, `tick`=1, `osc`=1.
  - If `cnt`==h-1 and `power[i]`=0: go to IDLE, `running`=0.
  - Otherwise `cnt`++.
- Power deassertion anywhere mid-period therefore finishes the full current period, high then low, before stopping. No runt pulses ever appear on `osc`.
- `align`=1 on an edge: every channel with `power[i]`=1 is forced to the HIGH entry action (`cnt`=0, relatch `h`, `osc`=1, `tick`=1), regardless of current state.
  - If the channel was already HIGH, `osc` stays 1 and the high phase restarts, lengthening it. `tick` still pulses.
  - Channels with `power[i]`=0 ignore `align` and continue their stop sequence.
- Channels are fully independent apart from the shared `align`.

## Timing
- Reset: on the edge with `reset`=1, all channels go to IDLE with `osc`=0, `tick`=0, `running`=0, `cnt`=0 and `h`=1.
  - Reset overrides `align` and `power` on the same edge.
  - Reset mid-period truncates the pulse immediately. This is the only permitted runt.
- Start latency: `power[i]` sampled 1 at edge k while IDLE gives `osc[i]`=1, `tick[i]`=1 and `running[i]`=1 after edge k.
- Steady state: `osc` is high for exactly h edges and low for exactly h edges. `tick` pulses every 2·h cycles.
- Stop latency: `power` falling during a period means `running` falls on the edge that would have started the next HIGH. `osc` is already 0 by then.
- With h=1, `osc` toggles every cycle (1,0,1,0…) and `tick` pulses every other cycle.
- Counter never exceeds h-1, so there is no overflow or wrap beyond the `DIV_WIDTH` range. The maximum half-period is 2^`DIV_WIDTH`−1.

## Test plan
- Reset and basic start: CHANNELS=4, DIV_WIDTH=8, `half_period`[0]=3, power[0] raised at edge 10.
  - Required: `osc[0]` is 1 for edges 10–12 and 0 for edges 13–15, repeating every 6 cycles.
  - Required: `tick[0]` is high only at edges 10, 16, 22…
  - Required: all other channels stay 0.
- Zero/one half-period: `half_period`=0 and `half_period`=1 on two channels, both powered.
  - Required: both outputs toggle every cycle, identical waveforms.
- Glitch-free stop: h=4, power dropped on the 2nd cycle of HIGH.
  - Required: `osc` completes 4 high and 4 low cycles, then `running` falls. There is no further `tick`.
- Mid-period reprogram: h=2 running, `half_period` changed to 5 during LOW.
  - Required: the current period stays 2+2. The next period is 5+5, starting with its `tick`.
- Align: ch0 h=3 and ch1 h=5 running out of phase, `align` pulsed.
  - Required: both channels have `osc`=1 and `tick`=1 on the next cycle, with `cnt`=0.
  - Required: an unpowered-but-stopping ch2 is unaffected.
- Reset mid-HIGH with `align`=1 and all channels powered on the same edge.
  - Required: every output is 0 next cycle.
  - Required: with power held high, channels restart one edge after reset is released.
